// File: rtl/vram_write_sched.sv
// vram_write_sched: shares the framebuffer VRAM write port between a host
// pixel-write stream and a rectangle-fill engine. Writes are arbitrated
// round-robin under contention and presented to the port one cycle after
// the grant through a registered output stage.

module vram_write_sched #(
    parameter int DW = 24,
    parameter int AW = 16
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic            host_valid,
    output logic            host_ready,
    input  logic [AW-1:0]   host_adr,
    input  logic [DW-1:0]   host_d,
    input  logic            fill_start,
    input  logic [AW/2-1:0] fill_x0,
    input  logic [AW/2-1:0] fill_y0,
    input  logic [AW/2-1:0] fill_x1,
    input  logic [AW/2-1:0] fill_y1,
    input  logic [DW-1:0]   fill_color,
    output logic            fill_busy,
    output logic            fill_done,
    output logic [AW-1:0]   vram_wadr,
    output logic            vram_we,
    output logic [DW-1:0]   vram_d
);

    localparam int HW = AW / 2;

    // Round-robin memory: which requester won the most recent contended cycle
    localparam logic RR_HOST = 1'b0;
    localparam logic RR_FILL = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t        state;
    logic [HW-1:0] x0_q;
    logic [HW-1:0] x1_q;
    logic [HW-1:0] y1_q;
    logic [HW-1:0] cx;
    logic [HW-1:0] cy;
    logic [DW-1:0] color_q;
    logic          rr_last;

    logic          fill_req;
    logic          contended;
    logic          grant_host;
    logic          grant_fill;
    logic          row_end;
    logic          last_pixel;
    logic          degenerate;

    // Combinational arbitration: one grant per cycle, alternate under contention
    always_comb begin
        fill_req   = (state == FILL);
        contended  = host_valid && fill_req;
        grant_host = host_valid && (!fill_req || (rr_last == RR_FILL));
        grant_fill = fill_req && !grant_host;
        host_ready = grant_host;
        row_end    = (cx == x1_q);
        last_pixel = row_end && (cy == y1_q);
        degenerate = (fill_x1 < fill_x0) || (fill_y1 < fill_y0);
    end

    // Remember the winner of each contended cycle; uncontended grants leave it alone
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rr_last <= RR_FILL;
        end else if (contended) begin
            rr_last <= grant_host ? RR_HOST : RR_FILL;
        end
    end

    // Fill engine: latch the rectangle, walk it row by row on each fill grant
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            fill_busy <= 1'b0;
            fill_done <= 1'b0;
            x0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            cx        <= '0;
            cy        <= '0;
            color_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    fill_done <= 1'b0;
                    if (fill_start) begin
                        x0_q      <= fill_x0;
                        x1_q      <= fill_x1;
                        y1_q      <= fill_y1;
                        cx        <= fill_x0;
                        cy        <= fill_y0;
                        color_q   <= fill_color;
                        fill_busy <= 1'b1;
                        if (degenerate) begin
                            state     <= DONE;
                            fill_done <= 1'b1;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (grant_fill) begin
                        if (last_pixel) begin
                            state     <= DONE;
                            fill_done <= 1'b1;
                        end else if (row_end) begin
                            cx <= x0_q;
                            cy <= cy + HW'(1);
                        end else begin
                            cx <= cx + HW'(1);
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    fill_busy <= 1'b0;
                    fill_done <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    fill_busy <= 1'b0;
                    fill_done <= 1'b0;
                end
            endcase
        end
    end

    // Registered write port: the granted write appears on the port one cycle later
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            vram_we   <= 1'b0;
            vram_wadr <= '0;
            vram_d    <= '0;
        end else if (grant_host) begin
            vram_we   <= 1'b1;
            vram_wadr <= host_adr;
            vram_d    <= host_d;
        end else if (grant_fill) begin
            vram_we   <= 1'b1;
            vram_wadr <= {cy, cx};
            vram_d    <= color_q;
        end else begin
            vram_we   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vram_write_sched.sv
// tb_vram_write_sched: directed bench for the VRAM write scheduler. A
// vector table covers host-only traffic; hand-written sequences cover fills,
// contention, degenerate and corner rectangles and reset during a fill.

module tb_vram_write_sched;

    localparam int DW = 24;
    localparam int AW = 16;

    logic            CLOCK_50 = 1'b0;
    logic            reset;
    logic            host_valid;
    logic            host_ready;
    logic [AW-1:0]   host_adr;
    logic [DW-1:0]   host_d;
    logic            fill_start;
    logic [AW/2-1:0] fill_x0;
    logic [AW/2-1:0] fill_y0;
    logic [AW/2-1:0] fill_x1;
    logic [AW/2-1:0] fill_y1;
    logic [DW-1:0]   fill_color;
    logic            fill_busy;
    logic            fill_done;
    logic [AW-1:0]   vram_wadr;
    logic            vram_we;
    logic [DW-1:0]   vram_d;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Port monitor: every write seen on the port, and fill_done pulses
    logic [AW-1:0] wadr_q[$];
    logic [DW-1:0] wd_q[$];
    int            done_cnt;

    // Expected write sequence for the current sequence
    logic [AW-1:0] ea_q[$];
    logic [DW-1:0] ed_q[$];

    typedef struct {
        logic          valid;
        logic [AW-1:0] adr;
        logic [DW-1:0] d;
        logic          exp_ready;
        logic          exp_we;
        logic [AW-1:0] exp_adr;
        logic [DW-1:0] exp_d;
    } vec_t;

    vec_t vecs[6];

    int   idx;
    logic rdy;
    bit   seen;
    bit   got;

    vram_write_sched #(.DW(DW), .AW(AW)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_adr   (host_adr),
        .host_d     (host_d),
        .fill_start (fill_start),
        .fill_x0    (fill_x0),
        .fill_y0    (fill_y0),
        .fill_x1    (fill_x1),
        .fill_y1    (fill_y1),
        .fill_color (fill_color),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .vram_wadr  (vram_wadr),
        .vram_we    (vram_we),
        .vram_d     (vram_d)
    );

    // 50 MHz-style free-running clock
    always #5 CLOCK_50 = ~CLOCK_50;

    // Sample the port away from the active edge
    always @(negedge CLOCK_50) begin
        if (vram_we) begin
            wadr_q.push_back(vram_wadr);
            wd_q.push_back(vram_d);
        end
        if (fill_done) done_cnt++;
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mon_clear();
        wadr_q.delete();
        wd_q.delete();
        ea_q.delete();
        ed_q.delete();
        done_cnt = 0;
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check_output({tag, "_write_count"}, 64'(wadr_q.size()), 64'(ea_q.size()));
        n = (wadr_q.size() < ea_q.size()) ? wadr_q.size() : ea_q.size();
        for (int i = 0; i < n; i++) begin
            check_output($sformatf("%s_adr%0d", tag, i), 64'(wadr_q[i]), 64'(ea_q[i]));
            check_output($sformatf("%s_d%0d", tag, i), 64'(wd_q[i]), 64'(ed_q[i]));
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] x0, input logic [7:0] y0,
                                  input logic [7:0] x1, input logic [7:0] y1,
                                  input logic [23:0] color);
        fill_x0    = x0;
        fill_y0    = y0;
        fill_x1    = x1;
        fill_y1    = y1;
        fill_color = color;
        fill_start = 1'b1;
    endtask

    // Waits at negedges for fill_done, bounded by a cycle budget
    task automatic wait_done(input int budget, output bit found);
        found = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge CLOCK_50);
            if (fill_done) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        host_valid = 1'b0;
        host_adr   = '0;
        host_d     = '0;
        fill_start = 1'b0;
        fill_x0    = '0;
        fill_y0    = '0;
        fill_x1    = '0;
        fill_y1    = '0;
        fill_color = '0;
        done_cnt   = 0;

        // Host-only vectors; expected port values are the result of the previous row
        vecs[0] = '{1'b1, 16'h0102, 24'hFF0000, 1'b1, 1'b0, 16'h0000, 24'h000000};
        vecs[1] = '{1'b1, 16'h0A0B, 24'h123456, 1'b1, 1'b1, 16'h0102, 24'hFF0000};
        vecs[2] = '{1'b0, 16'h0000, 24'h000000, 1'b0, 1'b1, 16'h0A0B, 24'h123456};
        vecs[3] = '{1'b0, 16'h0000, 24'h000000, 1'b0, 1'b0, 16'h0000, 24'h000000};
        vecs[4] = '{1'b1, 16'hFFFF, 24'h0000FF, 1'b1, 1'b0, 16'h0000, 24'h000000};
        vecs[5] = '{1'b0, 16'h0000, 24'h000000, 1'b0, 1'b1, 16'hFFFF, 24'h0000FF};

        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check_output("rst_we", vram_we, 0);
        check_output("rst_wadr", vram_wadr, 0);
        check_output("rst_d", vram_d, 0);
        check_output("rst_busy", fill_busy, 0);
        check_output("rst_done", fill_done, 0);
        check_output("rst_ready", host_ready, 0);
        reset = 1'b0;
        @(posedge CLOCK_50); #1;

        $display("[TB] host-only vectors");
        for (int i = 0; i < 6; i++) begin
            host_valid = vecs[i].valid;
            host_adr   = vecs[i].adr;
            host_d     = vecs[i].d;
            @(negedge CLOCK_50);
            check_output($sformatf("vec%0d_ready", i), host_ready, vecs[i].exp_ready);
            check_output($sformatf("vec%0d_we", i), vram_we, vecs[i].exp_we);
            if (vecs[i].exp_we) begin
                check_output($sformatf("vec%0d_wadr", i), vram_wadr, vecs[i].exp_adr);
                check_output($sformatf("vec%0d_d", i), vram_d, vecs[i].exp_d);
            end
            @(posedge CLOCK_50); #1;
        end
        host_valid = 1'b0;
        @(posedge CLOCK_50); #1;

        $display("[TB] basic fill 2..4 x 3..4");
        mon_clear();
        apply_stimulus(8'd2, 8'd3, 8'd4, 8'd4, 24'h00FF00);
        @(negedge CLOCK_50);
        check_output("t2_busy_before", fill_busy, 0);
        @(posedge CLOCK_50); #1;
        fill_start = 1'b0;
        @(negedge CLOCK_50);
        check_output("t2_busy_rise", fill_busy, 1);
        wait_done(40, seen);
        check_output("t2_done_seen", seen, 1);
        check_output("t2_done_we", vram_we, 1);
        check_output("t2_done_wadr", vram_wadr, 16'h0404);
        @(negedge CLOCK_50);
        check_output("t2_done_pulse", fill_done, 0);
        check_output("t2_busy_fall", fill_busy, 0);
        @(posedge CLOCK_50); #1;
        ea_q = '{16'h0302, 16'h0303, 16'h0304, 16'h0402, 16'h0403, 16'h0404};
        for (int i = 0; i < 6; i++) ed_q.push_back(24'h00FF00);
        compare_writes("t2");
        check_output("t2_done_count", 64'(done_cnt), 1);

        $display("[TB] fill against a host stream");
        mon_clear();
        apply_stimulus(8'd2, 8'd3, 8'd4, 8'd4, 24'h00FF00);
        @(posedge CLOCK_50); #1;
        fill_start = 1'b0;
        host_valid = 1'b1;
        host_adr   = 16'h1000;
        host_d     = 24'hAA0000;
        idx        = 0;
        for (int c = 0; c < 30 && idx < 6; c++) begin
            @(negedge CLOCK_50);
            rdy = host_ready;
            if (c < 11) check_output($sformatf("t3_ready_c%0d", c), rdy, 64'((c % 2) == 0));
            @(posedge CLOCK_50); #1;
            if (rdy) begin
                idx++;
                if (idx == 6) begin
                    host_valid = 1'b0;
                end else begin
                    host_adr = 16'h1000 + 16'(idx);
                    host_d   = 24'hAA0000 + 24'(idx);
                end
            end
        end
        host_valid = 1'b0;
        check_output("t3_host_accepted", 64'(idx), 6);
        wait_done(40, seen);
        check_output("t3_done_seen", seen, 1);
        check_output("t3_done_wadr", vram_wadr, 16'h0404);
        @(posedge CLOCK_50); #1;
        begin
            logic [15:0] fa[6];
            fa = '{16'h0302, 16'h0303, 16'h0304, 16'h0402, 16'h0403, 16'h0404};
            for (int i = 0; i < 6; i++) begin
                ea_q.push_back(16'h1000 + 16'(i));
                ed_q.push_back(24'hAA0000 + 24'(i));
                ea_q.push_back(fa[i]);
                ed_q.push_back(24'h00FF00);
            end
        end
        compare_writes("t3");
        check_output("t3_done_count", 64'(done_cnt), 1);

        $display("[TB] degenerate fill x1<x0");
        mon_clear();
        apply_stimulus(8'd5, 8'd0, 8'd4, 8'd0, 24'h0F0F0F);
        @(negedge CLOCK_50);
        check_output("t4_done_early", fill_done, 0);
        @(posedge CLOCK_50); #1;
        fill_start = 1'b0;
        @(negedge CLOCK_50);
        check_output("t4_done", fill_done, 1);
        check_output("t4_we", vram_we, 0);
        @(negedge CLOCK_50);
        check_output("t4_done_pulse", fill_done, 0);
        check_output("t4_busy_fall", fill_busy, 0);
        @(negedge CLOCK_50); #1;
        compare_writes("t4");
        check_output("t4_done_count", 64'(done_cnt), 1);
        @(posedge CLOCK_50); #1;

        $display("[TB] corner fill at 255");
        mon_clear();
        apply_stimulus(8'd254, 8'd255, 8'd255, 8'd255, 24'h0000FF);
        @(posedge CLOCK_50); #1;
        fill_start = 1'b0;
        wait_done(20, seen);
        check_output("t5_done_seen", seen, 1);
        check_output("t5_done_wadr", vram_wadr, 16'hFFFF);
        @(negedge CLOCK_50);
        check_output("t5_busy_fall", fill_busy, 0);
        repeat (3) @(negedge CLOCK_50);
        #1;
        ea_q = '{16'hFFFE, 16'hFFFF};
        ed_q = '{24'h0000FF, 24'h0000FF};
        compare_writes("t5");
        check_output("t5_done_count", 64'(done_cnt), 1);
        @(posedge CLOCK_50); #1;

        $display("[TB] reset during a 100-pixel fill");
        mon_clear();
        apply_stimulus(8'd10, 8'd20, 8'd19, 8'd29, 24'h123456);
        @(posedge CLOCK_50); #1;
        fill_start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLOCK_50); #1;
            if (wadr_q.size() >= 10) begin
                got = 1'b1;
                break;
            end
        end
        check_output("t6_ten_writes_seen", got, 1);
        reset = 1'b1;
        #1;
        check_output("t6_rst_we", vram_we, 0);
        check_output("t6_rst_busy", fill_busy, 0);
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        #1;
        for (int i = 0; i < 10; i++) begin
            ea_q.push_back(16'h1400 + 16'(10 + i));
            ed_q.push_back(24'h123456);
        end
        compare_writes("t6_old");
        check_output("t6_no_done", 64'(done_cnt), 0);

        mon_clear();
        @(posedge CLOCK_50); #1;
        apply_stimulus(8'd1, 8'd2, 8'd2, 8'd2, 24'hABCDEF);
        @(posedge CLOCK_50); #1;
        fill_start = 1'b0;
        wait_done(20, seen);
        check_output("t6_new_done_seen", seen, 1);
        check_output("t6_new_done_wadr", vram_wadr, 16'h0202);
        @(posedge CLOCK_50); #1;
        ea_q = '{16'h0201, 16'h0202};
        ed_q = '{24'hABCDEF, 24'hABCDEF};
        compare_writes("t6_new");
        check_output("t6_new_done_count", 64'(done_cnt), 1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
